// File: rtl/vga_pixel_scan_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_scan_fetch
// Brief    : 640x480@60 raster timing plus 4x-replicated 160x120 framebuffer
//            fetch, with sync/blank aligned to the downstream palette register.
// Revision : 1.0
// ============================================================================
module vga_pixel_scan_fetch #(
    parameter int   H_ACTIVE          = 640,
    parameter int   H_FRONT           = 16,
    parameter int   H_SYNC            = 96,
    parameter int   H_BACK            = 48,
    parameter int   V_ACTIVE          = 480,
    parameter int   V_FRONT           = 10,
    parameter int   V_SYNC            = 2,
    parameter int   V_BACK            = 33,
    parameter logic SYNC_ACTIVE_LEVEL = 1'b0,
    parameter int   SYNC_DELAY        = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [14:0] fb_address,
    input  logic [7:0]  fb_data,
    output logic [7:0]  pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start
);

    // Counters are 10 bits wide because the address is built from h[9:2]/v[8:2].
    localparam logic [9:0] c_h_max      = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_v_max      = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] c_hs_end     = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_start   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] c_vs_end     = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic       c_sync_idle  = ~SYNC_ACTIVE_LEVEL;

    logic [9:0]            r_h_count;
    logic [9:0]            r_v_count;
    logic [14:0]           r_fb_address;
    logic [1:0]            r_active_dly;
    logic [7:0]            r_pixel;
    logic [SYNC_DELAY-1:0] r_hsync_sr;
    logic [SYNC_DELAY-1:0] r_vsync_sr;
    logic [SYNC_DELAY-1:0] r_blank_sr;
    logic [SYNC_DELAY-1:0] r_frame_sr;

    logic w_active;
    logic w_hsync_raw;
    logic w_vsync_raw;
    logic w_frame_start_raw;

    always_comb begin
        w_active          = (r_h_count < c_h_active) && (r_v_count < c_v_active);
        w_hsync_raw       = ((r_h_count >= c_hs_start) && (r_h_count <= c_hs_end))
                          ? SYNC_ACTIVE_LEVEL : c_sync_idle;
        w_vsync_raw       = ((r_v_count >= c_vs_start) && (r_v_count <= c_vs_end))
                          ? SYNC_ACTIVE_LEVEL : c_sync_idle;
        w_frame_start_raw = (r_h_count == 10'd0) && (r_v_count == 10'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h_count <= 10'd0;
            r_v_count <= 10'd0;
        end else if (r_h_count == c_h_max) begin
            r_h_count <= 10'd0;
            r_v_count <= (r_v_count == c_v_max) ? 10'd0 : r_v_count + 10'd1;
        end else begin
            r_h_count <= r_h_count + 10'd1;
        end
    end

    // Dropping the low two bits of each counter gives the 4x4 pixel replication.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fb_address <= 15'd0;
            r_active_dly <= 2'b00;
            r_pixel      <= 8'h00;
        end else begin
            r_fb_address <= w_active ? {r_v_count[8:2], r_h_count[9:2]} : 15'd0;
            r_active_dly <= {r_active_dly[0], w_active};
            r_pixel      <= r_active_dly[1] ? fb_data : 8'h00;
        end
    end

    // Timing flags travel SYNC_DELAY stages so they meet the palette's RGB output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hsync_sr <= {SYNC_DELAY{c_sync_idle}};
            r_vsync_sr <= {SYNC_DELAY{c_sync_idle}};
            r_blank_sr <= {SYNC_DELAY{1'b1}};
            r_frame_sr <= {SYNC_DELAY{1'b0}};
        end else begin
            r_hsync_sr <= {r_hsync_sr[SYNC_DELAY-2:0], w_hsync_raw};
            r_vsync_sr <= {r_vsync_sr[SYNC_DELAY-2:0], w_vsync_raw};
            r_blank_sr <= {r_blank_sr[SYNC_DELAY-2:0], ~w_active};
            r_frame_sr <= {r_frame_sr[SYNC_DELAY-2:0], w_frame_start_raw};
        end
    end

    assign fb_address  = r_fb_address;
    assign pixel       = r_pixel;
    assign hsync       = r_hsync_sr[SYNC_DELAY-1];
    assign vsync       = r_vsync_sr[SYNC_DELAY-1];
    assign blank       = r_blank_sr[SYNC_DELAY-1];
    assign frame_start = r_frame_sr[SYNC_DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_scan_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_scan_fetch
// Brief    : Directed bench: full-size instance for line-level behaviour and a
//            shrunken-timing instance for frame-level behaviour.
// Revision : 1.0
// ============================================================================
module tb_vga_pixel_scan_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [14:0] fb_address_a, fb_address_b;
    logic [7:0]  fb_data_a = 8'h00, fb_data_b = 8'h00;
    logic [7:0]  pixel_a, pixel_b;
    logic        hsync_a, vsync_a, blank_a, frame_start_a;
    logic        hsync_b, vsync_b, blank_b, frame_start_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    vga_pixel_scan_fetch dut_a (
        .clock(clock), .reset(reset),
        .fb_address(fb_address_a), .fb_data(fb_data_a),
        .pixel(pixel_a), .hsync(hsync_a), .vsync(vsync_a),
        .blank(blank_a), .frame_start(frame_start_a)
    );

    // Small raster: 24 clocks/line, 14 lines/frame, 336 clocks/frame.
    vga_pixel_scan_fetch #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE_LEVEL(1'b0), .SYNC_DELAY(4)
    ) dut_b (
        .clock(clock), .reset(reset),
        .fb_address(fb_address_b), .fb_data(fb_data_b),
        .pixel(pixel_b), .hsync(hsync_b), .vsync(vsync_b),
        .blank(blank_b), .frame_start(frame_start_b)
    );

    // Synchronous framebuffer RAMs: A holds low address byte (0xA5 at 0), B is all 0xFF.
    always @(posedge clock) begin
        fb_data_a <= (fb_address_a == 15'd0) ? 8'hA5 : fb_address_a[7:0];
        fb_data_b <= 8'hFF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int addr_bad = 0, hs_low = 0, hs_first = 0, hs_second = 0;
    int fs_a_count = 0, vs_a_low = 0;
    int fs_b_count = 0, fs_b_bad = 0, fs_b_first = 0, fs_b_last = 0;
    int vs_b_low = 0, vs_b_first = 0, hs_b_low = 0, act_b = 0, fill_bad = 0;
    logic [7:0]  prev_pixel_b = 8'h00;
    logic [14:0] exp_addr;
    int          h;

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        repeat (1000) @(posedge clock);
        #1;
        check("mid_pixel",   pixel_a,      8'h31);
        check("mid_addr",    fb_address_a, 15'h031);
        check("mid_blank",   blank_a,      1'b0);

        reset = 1'b1;
        #1;
        check("rst_pixel",   pixel_a,       8'h00);
        check("rst_blank",   blank_a,       1'b1);
        check("rst_hsync",   hsync_a,       1'b1);
        check("rst_vsync",   vsync_a,       1'b1);
        check("rst_addr",    fb_address_a,  15'd0);
        check("rst_fs",      frame_start_a, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        check("rst_hold_pixel", pixel_a, 8'h00);
        check("rst_hold_blank", blank_a, 1'b1);
        reset = 1'b0;

        for (int n = 1; n <= 4000; n++) begin
            @(posedge clock);
            #1;
            if (n <= 800) begin
                h = n - 1;
                exp_addr = (h < 640) ? 15'(h / 4) : 15'd0;
                if (fb_address_a !== exp_addr) addr_bad++;
            end
            if (n >= 4 && n <= 803 && hsync_a === 1'b0) begin
                hs_low++;
                if (hs_first == 0) hs_first = n;
            end
            if (n >= 804 && n <= 1603 && hsync_a === 1'b0 && hs_second == 0) hs_second = n;
            if (frame_start_a === 1'b1) fs_a_count++;
            if (vsync_a !== 1'b1) vs_a_low++;

            if (frame_start_b === 1'b1) begin
                fs_b_count++;
                if (fs_b_first == 0) fs_b_first = n;
                if (fs_b_last != 0 && (n - fs_b_last) != 336) fs_b_bad++;
                fs_b_last = n;
            end
            if (n >= 4 && n <= 339) begin
                if (vsync_b === 1'b0) begin
                    vs_b_low++;
                    if (vs_b_first == 0) vs_b_first = n;
                end
                if (hsync_b === 1'b0) hs_b_low++;
            end
            if (n >= 3 && n <= 338 && pixel_b === 8'hFF) act_b++;
            if (n >= 4 && prev_pixel_b !== (blank_b ? 8'h00 : 8'hFF)) fill_bad++;
            prev_pixel_b = pixel_b;

            case (n)
                1: begin
                    check("rel_addr_n1",  fb_address_a, 15'd0);
                    check("rel_blank_n1", blank_a,      1'b1);
                end
                2:    check("pixel_n2",     pixel_a,       8'h00);
                3: begin
                    check("pixel_first",  pixel_a,       8'hA5);
                    check("fs_n3",        frame_start_a, 1'b0);
                    check("blank_n3",     blank_a,       1'b1);
                end
                4: begin
                    check("fs_n4",        frame_start_a, 1'b1);
                    check("blank_fall",   blank_a,       1'b0);
                end
                5:    check("fs_n5",        frame_start_a, 1'b0);
                7:    check("pixel_x1",     pixel_a,       8'h01);
                637:  check("addr_x159",    fb_address_a,  15'h09F);
                641:  check("addr_h640",    fb_address_a,  15'd0);
                642:  check("pixel_x159",   pixel_a,       8'h9F);
                643: begin
                    check("pixel_h640",   pixel_a,       8'h00);
                    check("blank_h639",   blank_a,       1'b0);
                end
                644:  check("blank_h640",   blank_a,       1'b1);
                659:  check("hsync_h655",   hsync_a,       1'b1);
                660:  check("hsync_h656",   hsync_a,       1'b0);
                755:  check("hsync_h751",   hsync_a,       1'b0);
                756:  check("hsync_h752",   hsync_a,       1'b1);
                804:  check("blank_line1",  blank_a,       1'b0);
                3201: check("addr_y1_base", fb_address_a,  15'h100);
                3205: check("addr_y1_x1",   fb_address_a,  15'h101);
                3207: check("pixel_y1_x1",  pixel_a,       8'h01);
                default: ;
            endcase
        end

        check("addr_pattern_line0", addr_bad,   0);
        check("hsync_low_count",    hs_low,     96);
        check("hsync_first_low",    hs_first,   660);
        check("hsync_period",       hs_second,  1460);
        check("fs_a_pulses",        fs_a_count, 1);
        check("vsync_a_idle",       vs_a_low,   0);
        check("fs_b_pulses",        fs_b_count, 12);
        check("fs_b_interval",      fs_b_bad,   0);
        check("fs_b_first",         fs_b_first, 4);
        check("vsync_b_low_count",  vs_b_low,   48);
        check("vsync_b_first_low",  vs_b_first, 244);
        check("hsync_b_low_count",  hs_b_low,   42);
        check("active_b_count",     act_b,      128);
        check("blank_fill_b",       fill_bad,   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
